lfsr_stepper: RTL and testbench

Galois LFSR engine that consumes the slow square-wave clock from the board clock divider as a sampled data signal, not as a clock. The block runs entirely on the 100 MHz board clock CCLK. It advances one LFSR step per rising edge of that slow signal in run mode, or per single-step request in pause mode. It supports seed loading via a valid/ready handshake and reports step count and full-period completion to the display/LED stage downstream.

---
 rtl/lfsr_stepper_if.sv | 27 ++
 rtl/lfsr_stepper.sv | 118 +++++++++++
 tb/tb_lfsr_stepper.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_stepper_if.sv
// Signal bundle between the LFSR stepper and its surroundings.
// The master side drives the step sources and the seed offer. The slave side is the stepper.
interface lfsr_stepper_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             tick_clk;
    logic             run;
    logic             step_btn;
    logic             seed_valid;
    logic [WIDTH-1:0] seed_data;
    logic             seed_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [31:0]      step_count;
    logic             period_done;
    logic             seed_fault;

    modport master (
        output tick_clk, run, step_btn, seed_valid, seed_data,
        input  seed_ready, q, q_valid, step_count, period_done, seed_fault
    );

    modport slave (
        input  tick_clk, run, step_btn, seed_valid, seed_data,
        output seed_ready, q, q_valid, step_count, period_done, seed_fault
    );
endinterface

// File: rtl/lfsr_stepper.sv
// Galois LFSR stepped by rising edges of a sampled slow tick in run mode, or of a button in pause.
// Accepts seeds through a valid/ready handshake. Tracks the step count and full-period return.
module lfsr_stepper #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic          CCLK,
    input  logic          RSTN,
    lfsr_stepper_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StRun, StLoad} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [31:0]      count_q, count_d;
    logic             q_valid_q, q_valid_d;
    logic             period_q, period_d;
    logic             fault_q, fault_d;
    logic             tick_prev_q, btn_prev_q;

    logic             tick_rise, btn_rise;
    logic             seed_ready, load, step;
    logic [WIDTH-1:0] q_next;

    assign tick_rise  = bus_io.tick_clk & ~tick_prev_q;
    assign btn_rise   = bus_io.step_btn & ~btn_prev_q;
    assign seed_ready = (state_q != StLoad);
    assign load       = bus_io.seed_valid & seed_ready;
    assign q_next     = q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        start_d   = start_q;
        count_d   = count_q;
        q_valid_d = 1'b0;
        period_d  = period_q;
        fault_d   = fault_q;
        step      = 1'b0;

        // Edge qualification and run changes both follow the current state's rule.
        unique case (state_q)
            StIdle: begin
                step = btn_rise;
                if (bus_io.run) state_d = StRun;
            end
            StRun: begin
                step = tick_rise;
                if (!bus_io.run) state_d = StIdle;
            end
            StLoad: begin
                step    = 1'b0;
                state_d = bus_io.run ? StRun : StIdle;
            end
            default: begin
                step    = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A load takes priority over a coincident step, which is dropped.
        if (load) begin
            state_d  = StLoad;
            count_d  = '0;
            period_d = 1'b0;
            if (bus_io.seed_data == '0) begin
                q_d     = SEED;
                start_d = SEED;
                fault_d = 1'b1;
            end else begin
                q_d     = bus_io.seed_data;
                start_d = bus_io.seed_data;
                fault_d = 1'b0;
            end
        end else if (step) begin
            q_d       = q_next;
            q_valid_d = 1'b1;
            count_d   = count_q + 32'd1;
            if (q_next == start_q) period_d = 1'b1;
        end
    end

    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= StIdle;
            q_q         <= SEED;
            start_q     <= SEED;
            count_q     <= '0;
            q_valid_q   <= 1'b0;
            period_q    <= 1'b0;
            fault_q     <= 1'b0;
            // Held-high inputs at reset release must not look like rising edges.
            tick_prev_q <= 1'b1;
            btn_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            start_q     <= start_d;
            count_q     <= count_d;
            q_valid_q   <= q_valid_d;
            period_q    <= period_d;
            fault_q     <= fault_d;
            tick_prev_q <= bus_io.tick_clk;
            btn_prev_q  <= bus_io.step_btn;
        end
    end

    assign bus_io.seed_ready  = seed_ready;
    assign bus_io.q           = q_q;
    assign bus_io.q_valid     = q_valid_q;
    assign bus_io.step_count  = count_q;
    assign bus_io.period_done = period_q;
    assign bus_io.seed_fault  = fault_q;

endmodule

// File: tb/tb_lfsr_stepper.sv
// Directed bench for lfsr_stepper: a 16-bit instance for stepping, seeding and reset.
// A 4-bit instance covers a complete LFSR period within a short run.
module tb_lfsr_stepper;

    logic CCLK;
    logic RSTN;
    int   n_checks;
    int   n_fail;

    lfsr_stepper_if #(.WIDTH(16)) bus ();
    lfsr_stepper_if #(.WIDTH(4))  sbus ();

    lfsr_stepper #(
        .WIDTH (16),
        .TAPS  (16'hB400),
        .SEED  (16'hACE1)
    ) u_dut (
        .CCLK   (CCLK),
        .RSTN   (RSTN),
        .bus_io (bus)
    );

    // x^4+x^3+1 is maximal: starting from 1, the state returns to 1 after 15 steps.
    lfsr_stepper #(
        .WIDTH (4),
        .TAPS  (4'hC),
        .SEED  (4'h1)
    ) u_small (
        .CCLK   (CCLK),
        .RSTN   (RSTN),
        .bus_io (sbus)
    );

    initial begin
        CCLK = 1'b0;
        forever #5 CCLK = ~CCLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CCLK);
        #1;
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    logic [15:0] exp_q;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RSTN = 1'b1;
        bus.tick_clk = 1'b1;  bus.step_btn = 1'b1;  bus.run = 1'b0;
        bus.seed_valid = 1'b0; bus.seed_data = 16'h0000;
        sbus.tick_clk = 1'b0; sbus.step_btn = 1'b0; sbus.run = 1'b0;
        sbus.seed_valid = 1'b0; sbus.seed_data = 4'h0;

        // Asynchronous reset, asserted and checked before the first clock edge.
        #2 RSTN = 1'b0;
        #1;
        check_eq("rst_q",      32'(bus.q),           32'hACE1);
        check_eq("rst_qvalid", 32'(bus.q_valid),     32'h0);
        check_eq("rst_count",  bus.step_count,       32'h0);
        check_eq("rst_period", 32'(bus.period_done), 32'h0);
        check_eq("rst_fault",  32'(bus.seed_fault),  32'h0);
        cyc();
        cyc();
        RSTN = 1'b1;

        // Tick and button held high across reset release: no step.
        for (int i = 0; i < 10; i++) begin
            cyc();
            check_eq("hold_qvalid", 32'(bus.q_valid), 32'h0);
        end
        check_eq("hold_q",     32'(bus.q),          32'hACE1);
        check_eq("hold_count", bus.step_count,      32'h0);
        check_eq("hold_ready", 32'(bus.seed_ready), 32'h1);

        // IDLE: button pulses step; tick toggling is ignored.
        bus.step_btn = 1'b0; bus.tick_clk = 1'b0; cyc();
        bus.step_btn = 1'b1; bus.tick_clk = 1'b1; cyc();
        check_eq("btn1_q",      32'(bus.q),       32'hE270);
        check_eq("btn1_qvalid", 32'(bus.q_valid), 32'h1);
        bus.step_btn = 1'b0; bus.tick_clk = 1'b0; cyc();
        check_eq("btn1_pulse",  32'(bus.q_valid), 32'h0);
        bus.tick_clk = 1'b1; cyc();
        check_eq("idle_tick_q", 32'(bus.q),       32'hE270);
        check_eq("idle_tick_v", 32'(bus.q_valid), 32'h0);
        bus.step_btn = 1'b1; bus.tick_clk = 1'b0; cyc();
        check_eq("btn2_q",      32'(bus.q),       32'h7138);
        check_eq("btn2_qvalid", 32'(bus.q_valid), 32'h1);
        bus.step_btn = 1'b0; cyc();
        check_eq("btn2_count",  bus.step_count,   32'd2);

        // RUN: one step per tick rise, tick period 4 cycles, 35 steps to reach count 37.
        bus.run = 1'b1; bus.tick_clk = 1'b0; cyc();
        exp_q = 16'h7138;
        for (int i = 0; i < 35; i++) begin
            bus.tick_clk = 1'b1; cyc();
            exp_q = ref_next(exp_q);
            if (i == 0) begin
                check_eq("run_first_q", 32'(bus.q),       32'(exp_q));
                check_eq("run_first_v", 32'(bus.q_valid), 32'h1);
            end
            cyc();
            if (i == 0) check_eq("run_pulse", 32'(bus.q_valid), 32'h0);
            bus.tick_clk = 1'b0; cyc();
            cyc();
        end
        check_eq("run_q",     32'(bus.q),     32'(exp_q));
        check_eq("run_count", bus.step_count, 32'd37);

        // Reset mid-RUN takes effect without a clock edge.
        #2 RSTN = 1'b0;
        #1;
        check_eq("midrst_q",     32'(bus.q),       32'hACE1);
        check_eq("midrst_count", bus.step_count,   32'h0);
        check_eq("midrst_v",     32'(bus.q_valid), 32'h0);
        bus.run = 1'b0;
        cyc();
        RSTN = 1'b1;
        cyc();
        // Back in IDLE: a tick rise must not step, a button rise must.
        bus.tick_clk = 1'b1; cyc();
        check_eq("post_rst_tick", 32'(bus.q_valid), 32'h0);
        check_eq("post_rst_q",    32'(bus.q),       32'hACE1);
        bus.step_btn = 1'b1; cyc();
        check_eq("post_rst_btn",  32'(bus.q),       32'hE270);
        bus.step_btn = 1'b0; bus.tick_clk = 1'b0; cyc();

        // Seed 0001 loads, LOAD lasts one cycle, then the next step gives B400.
        bus.seed_valid = 1'b1; bus.seed_data = 16'h0001; cyc();
        check_eq("seed1_q",     32'(bus.q),          32'h0001);
        check_eq("seed1_ready", 32'(bus.seed_ready), 32'h0);
        check_eq("seed1_count", bus.step_count,      32'h0);
        bus.seed_valid = 1'b0; cyc();
        check_eq("seed1_ready2", 32'(bus.seed_ready), 32'h1);
        bus.step_btn = 1'b1; cyc();
        check_eq("seed1_step", 32'(bus.q), 32'hB400);
        bus.step_btn = 1'b0; cyc();

        // Zero seed is replaced by the reset seed and flagged.
        bus.seed_valid = 1'b1; bus.seed_data = 16'h0000; cyc();
        check_eq("seed0_q",     32'(bus.q),          32'hACE1);
        check_eq("seed0_fault", 32'(bus.seed_fault), 32'h1);
        bus.seed_valid = 1'b0; cyc();

        // Seed offer coincident with a tick rise in RUN: load wins, no pulse.
        bus.run = 1'b1; cyc();
        cyc();
        bus.tick_clk = 1'b1; bus.seed_valid = 1'b1; bus.seed_data = 16'h1234; cyc();
        check_eq("coll_q",     32'(bus.q),          32'h1234);
        check_eq("coll_count", bus.step_count,      32'h0);
        check_eq("coll_v",     32'(bus.q_valid),    32'h0);
        check_eq("coll_fault", 32'(bus.seed_fault), 32'h0);
        bus.seed_valid = 1'b0; cyc();
        check_eq("coll_v2",    32'(bus.q_valid),    32'h0);
        bus.tick_clk = 1'b0; cyc();
        bus.tick_clk = 1'b1; cyc();
        check_eq("coll_step_q", 32'(bus.q),     32'h091A);
        check_eq("coll_step_n", bus.step_count, 32'd1);

        // Full period on the 4-bit instance, tick toggling every cycle.
        sbus.run = 1'b1; cyc();
        for (int i = 1; i <= 15; i++) begin
            sbus.tick_clk = 1'b1; cyc();
            if (i == 1)  check_eq("small_first_q", 32'(sbus.q), 32'hC);
            if (i == 14) check_eq("small_pre_done", 32'(sbus.period_done), 32'h0);
            sbus.tick_clk = 1'b0; cyc();
        end
        check_eq("small_q",     32'(sbus.q),           32'h1);
        check_eq("small_done",  32'(sbus.period_done), 32'h1);
        check_eq("small_count", sbus.step_count,       32'd15);
        sbus.tick_clk = 1'b1; cyc();
        check_eq("small_sticky",  32'(sbus.period_done), 32'h1);
        check_eq("small_after_q", 32'(sbus.q),           32'hC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
